// File: rtl/pixel_array_ctrl.sv
// Pixel array sequencer: erase -> expose -> convert (ADC ramp) -> read12 -> read34.
// One shared phase counter times every phase. All outputs are registered and
// decoded from the next state, so each control is high exactly while its
// state is current.
module pixel_array_ctrl #(
  parameter int unsigned ERASE_CYC = 5,
  parameter int unsigned CONV_CYC  = 255,
  parameter int unsigned READ_CYC  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [15:0] exp_time,
  input  logic [7:0] pix_d1,
  input  logic [7:0] pix_d2,
  input  logic [7:0] pix_d3,
  input  logic [7:0] pix_d4,
  output logic       erase,
  output logic       expose,
  output logic       convert,
  output logic       read12,
  output logic       read34,
  output logic [7:0] adc_data,
  output logic       adc_oe,
  output logic [7:0] pix_out1,
  output logic [7:0] pix_out2,
  output logic [7:0] pix_out3,
  output logic [7:0] pix_out4,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ12  = 3'd4,
    S_READ34  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [15:0] r_exp;
  logic        w_last;

  logic       r_erase, r_expose, r_convert, r_read12, r_read34;
  logic [7:0] r_adc_data;
  logic       r_adc_oe;
  logic [7:0] r_pix1, r_pix2, r_pix3, r_pix4;
  logic       r_busy, r_frame_done;

  // Detect the final cycle of the current phase.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_ERASE:   w_last = (r_cnt == 16'(ERASE_CYC - 1));
      S_EXPOSE:  w_last = (r_cnt == (r_exp - 16'd1));
      S_CONVERT: w_last = (r_cnt == 16'(CONV_CYC - 1));
      S_READ12:  w_last = (r_cnt == 16'(READ_CYC - 1));
      S_READ34:  w_last = (r_cnt == 16'(READ_CYC - 1));
      default:   w_last = 1'b0;
    endcase
  end

  // Next-state and next-counter logic; abort wins over start and phase timing.
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE) begin
      if (start && !abort) begin
        w_next = S_ERASE;
      end else begin
        w_next = S_IDLE;
      end
    end else if (abort) begin
      w_next = S_IDLE;
    end else if (w_last) begin
      case (r_state)
        S_ERASE:   w_next = S_EXPOSE;
        S_EXPOSE:  w_next = S_CONVERT;
        S_CONVERT: w_next = S_READ12;
        S_READ12:  w_next = S_READ34;
        S_READ34:  w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end else begin
      w_next = r_state;
    end

    if ((w_next != r_state) || (w_next == S_IDLE)) begin
      w_cnt_next = 16'd0;
    end else begin
      w_cnt_next = r_cnt + 16'd1;
    end
  end

  // State, phase counter and latched exposure length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_exp   <= 16'd1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if ((r_state == S_IDLE) && (w_next == S_ERASE)) begin
        r_exp <= (exp_time == 16'd0) ? 16'd1 : exp_time;
      end
    end
  end

  // Registered Moore outputs decoded from the upcoming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_erase      <= 1'b0;
      r_expose     <= 1'b0;
      r_convert    <= 1'b0;
      r_read12     <= 1'b0;
      r_read34     <= 1'b0;
      r_adc_data   <= 8'd0;
      r_adc_oe     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_erase      <= (w_next == S_ERASE);
      r_expose     <= (w_next == S_EXPOSE);
      r_convert    <= (w_next == S_CONVERT);
      r_read12     <= (w_next == S_READ12);
      r_read34     <= (w_next == S_READ34);
      r_adc_data   <= (w_next == S_CONVERT) ? w_cnt_next[7:0] : 8'd0;
      r_adc_oe     <= (w_next == S_CONVERT);
      r_busy       <= (w_next != S_IDLE);
      r_frame_done <= (r_state == S_READ34) && w_last && !abort;
    end
  end

  // Pixel capture at the end of each read phase; aborted phases keep old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix1 <= 8'd0;
      r_pix2 <= 8'd0;
      r_pix3 <= 8'd0;
      r_pix4 <= 8'd0;
    end else begin
      if ((r_state == S_READ12) && w_last && !abort) begin
        r_pix1 <= pix_d1;
        r_pix2 <= pix_d2;
      end
      if ((r_state == S_READ34) && w_last && !abort) begin
        r_pix3 <= pix_d3;
        r_pix4 <= pix_d4;
      end
    end
  end

  assign erase      = r_erase;
  assign expose     = r_expose;
  assign convert    = r_convert;
  assign read12     = r_read12;
  assign read34     = r_read34;
  assign adc_data   = r_adc_data;
  assign adc_oe     = r_adc_oe;
  assign pix_out1   = r_pix1;
  assign pix_out2   = r_pix2;
  assign pix_out3   = r_pix3;
  assign pix_out4   = r_pix4;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Scoreboard bench for pixel_array_ctrl: stimulus pushes per-frame expectations,
// a monitor measures each frame and compares when frame_done is presented.
module tb_pixel_array_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [15:0] exp_time = 16'd0;
  logic [7:0] pix_d1 = 8'd0, pix_d2 = 8'd0, pix_d3 = 8'd0, pix_d4 = 8'd0;
  logic       erase, expose, convert, read12, read34;
  logic [7:0] adc_data;
  logic       adc_oe;
  logic [7:0] pix_out1, pix_out2, pix_out3, pix_out4;
  logic       busy, frame_done;

  pixel_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .exp_time(exp_time),
    .pix_d1(pix_d1), .pix_d2(pix_d2), .pix_d3(pix_d3), .pix_d4(pix_d4),
    .erase(erase), .expose(expose), .convert(convert), .read12(read12), .read34(read34),
    .adc_data(adc_data), .adc_oe(adc_oe),
    .pix_out1(pix_out1), .pix_out2(pix_out2), .pix_out3(pix_out3), .pix_out4(pix_out4),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         erase_n;
    int         expose_n;
    int         conv_n;
    int         r12_n;
    int         r34_n;
    int         busy_n;
    logic [7:0] p1, p2, p3, p4;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int g_onehot_err = 0;
  int g_ramp_err = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push_frame(input int expo, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    frame_t f;
    f.erase_n  = 5;
    f.expose_n = expo;
    f.conv_n   = 255;
    f.r12_n    = 5;
    f.r34_n    = 5;
    f.busy_n   = 5 + expo + 255 + 5 + 5;
    f.p1 = a; f.p2 = b; f.p3 = c; f.p4 = d;
    exp_q.push_back(f);
  endtask

  // Monitor: per-frame measurements, compared against the scoreboard on frame_done.
  initial begin
    int n_er, n_ex, n_cv, n_r12, n_r34, n_busy, onehot_err, ramp_err;
    logic prev_erase, prev_r34;
    frame_t f;
    n_er = 0; n_ex = 0; n_cv = 0; n_r12 = 0; n_r34 = 0; n_busy = 0;
    onehot_err = 0; ramp_err = 0; prev_erase = 1'b0; prev_r34 = 1'b0;
    forever begin
      @(negedge clk);
      if (erase && !prev_erase) begin
        n_er = 0; n_ex = 0; n_cv = 0; n_r12 = 0; n_r34 = 0; n_busy = 0;
        onehot_err = 0; ramp_err = 0;
      end
      if ($countones({erase, expose, convert, read12, read34}) > 1) begin
        onehot_err++; g_onehot_err++;
      end
      if (convert) begin
        if ((adc_data != n_cv[7:0]) || !adc_oe) begin ramp_err++; g_ramp_err++; end
        n_cv++;
      end else if ((adc_data != 8'd0) || adc_oe) begin
        ramp_err++; g_ramp_err++;
      end
      if (erase)  n_er++;
      if (expose) n_ex++;
      if (read12) n_r12++;
      if (read34) n_r34++;
      if (busy)   n_busy++;
      if (read34 && !prev_r34 && exp_q.size() > 0) begin
        chk("pix_out1_after_read12", int'(pix_out1), int'(exp_q[0].p1));
        chk("pix_out2_after_read12", int'(pix_out2), int'(exp_q[0].p2));
      end
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          f = exp_q.pop_front();
          chk("erase_cycles", n_er, f.erase_n);
          chk("expose_cycles", n_ex, f.expose_n);
          chk("convert_cycles", n_cv, f.conv_n);
          chk("read12_cycles", n_r12, f.r12_n);
          chk("read34_cycles", n_r34, f.r34_n);
          chk("busy_cycles", n_busy, f.busy_n);
          chk("busy_in_done_cycle", int'(busy), 0);
          chk("onehot_errors", onehot_err, 0);
          chk("adc_ramp_errors", ramp_err, 0);
          chk("pix_out1", int'(pix_out1), int'(f.p1));
          chk("pix_out2", int'(pix_out2), int'(f.p2));
          chk("pix_out3", int'(pix_out3), int'(f.p3));
          chk("pix_out4", int'(pix_out4), int'(f.p4));
        end
      end
      prev_erase = erase;
      prev_r34 = read34;
    end
  end

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (!frame_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic set_pix(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    pix_d1 = a; pix_d2 = b; pix_d3 = c; pix_d4 = d;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_controls"}, int'({erase, expose, convert, read12, read34}), 0);
    chk({nm, "_adc_data"}, int'(adc_data), 0);
    chk({nm, "_adc_oe"}, int'(adc_oe), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Stimulus: directed frames, each pushing its expected measurements.
  initial begin
    int n;
    // Reset state.
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_pix_out", int'({pix_out1, pix_out2, pix_out3, pix_out4}), 0);

    // Frame 1: nominal, start on first edge with reset released.
    set_pix(8'h11, 8'h22, 8'h33, 8'h44);
    exp_time = 16'd10;
    push_frame(10, 8'h11, 8'h22, 8'h33, 8'h44);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("first_start_erase", int'(erase), 1);
    start = 1'b0;
    wait_done(400, "nominal");
    @(negedge clk);

    // Frame 2: exp_time 0 and start pulses while busy.
    set_pix(8'h55, 8'h66, 8'h77, 8'h88);
    exp_time = 16'd0;
    push_frame(1, 8'h55, 8'h66, 8'h77, 8'h88);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (40) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(400, "exp_zero");
    repeat (20) @(negedge clk);
    chk("no_queued_frame_busy", int'(busy), 0);

    // Frame 3: abort during convert at adc_data 100.
    set_pix(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    exp_time = 16'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(convert && adc_data == 8'd100) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_adc_100", int'(convert && adc_data == 8'd100), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_outputs("abort");
    chk("abort_pix_kept", int'({pix_out1, pix_out2, pix_out3, pix_out4}), int'(32'h55667788));
    // Abort beats start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_over_start_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_frame_done", int'(frame_done), 0);

    // Frame 4: asynchronous reset during expose, then a nominal frame.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!expose && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_expose", int'(expose), 1);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    chk("async_reset_pix", int'({pix_out1, pix_out2, pix_out3, pix_out4}), 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("start_ignored_in_reset", int'(busy), 0);
    set_pix(8'h11, 8'h22, 8'h33, 8'h44);
    push_frame(10, 8'h11, 8'h22, 8'h33, 8'h44);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_erase", int'(erase), 1);
    start = 1'b0;
    wait_done(400, "post_reset");
    @(negedge clk);

    // Frames 5/6: start held high, back-to-back.
    set_pix(8'h12, 8'h34, 8'h56, 8'h78);
    exp_time = 16'd3;
    push_frame(3, 8'h12, 8'h34, 8'h56, 8'h78);
    push_frame(3, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    start = 1'b1;
    @(negedge clk);
    wait_done(400, "b2b_first");
    chk("b2b_done_busy", int'(busy), 0);
    set_pix(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    @(negedge clk);
    chk("b2b_erase_next", int'(erase), 1);
    start = 1'b0;
    wait_done(400, "b2b_second");
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("global_onehot_errors", g_onehot_err, 0);
    chk("global_adc_errors", g_ramp_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
